// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 3-bit opcodes OP_ADD .. OP_MUL
//   - FSM state encoding (ST_IDLE, ST_MUL)
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_shiftadd.sv
// alu_mul_shiftadd: unsigned WIDTH x WIDTH shift-add multiplier.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture a/b, clear accumulator, arm counter with WIDTH
//   a, b        : multiplicand / multiplier
//   fin         : high while the final step is being taken this cycle
//   prod        : {acc, multiplier} as it will be after this cycle's step;
//                 on the fin cycle this is the complete 2*WIDTH-bit product
module alu_mul_shiftadd #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               fin,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sum;

  // One extra bit keeps the carry out of the add; it becomes the acc MSB
  // after the right shift.
  assign w_sum = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign prod  = {w_sum, r_mplier[WIDTH-1:1]};
  assign fin   = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_mcand  <= a;
      r_acc    <= '0;
      r_mplier <= b;
      r_cnt    <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc    <= w_sum[WIDTH:1];
      r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU, one operation per accepted start.
// Single-cycle ops produce done one clock after start; MUL runs WIDTH
// shift-add steps and produces done WIDTH+1 clocks after start.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start, A, B, ALUOp     : request + operands/opcode (sampled in IDLE)
//   busy                   : multiply in progress
//   done                   : one-cycle pulse, new result valid
//   resultado/resultado_hi : low/high result words (hi only nonzero for MUL)
//   zero, eq, carry, negative, overflow : status flags, held with result
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultado_hi,
  output logic             zero,
  output logic             eq,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t           r_state;
  logic             r_mul_eq;   // A==B of the operands captured for MUL
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_mul_load;
  logic             w_fin;
  logic [2*WIDTH-1:0] w_prod;

  assign w_mul_load = (r_state == ST_IDLE) && start && (ALUOp == OP_MUL);

  alu_mul_shiftadd #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (w_mul_load),
    .a    (A),
    .b    (B),
    .fin  (w_fin),
    .prod (w_prod)
  );

  // Single-cycle datapath on the live bus; only used when start is taken.
  always_comb begin
    w_sum   = {1'b0, A} + {1'b0, B};
    w_diff  = {1'b0, A} - {1'b0, B};
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];   // borrow out == A < B unsigned
        w_ovf   = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
      end
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_PASS: w_res = A;
      OP_XOR:  w_res = A ^ B;
      OP_SHL:  w_res = A << B[SHW-1:0];
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mul_eq     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      resultado    <= '0;
      resultado_hi <= '0;
      zero         <= 1'b1;
      eq           <= 1'b1;
      carry        <= 1'b0;
      negative     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (ALUOp == OP_MUL) begin
              r_state  <= ST_MUL;
              busy     <= 1'b1;
              r_mul_eq <= (A == B);
            end else begin
              resultado    <= w_res;
              resultado_hi <= '0;
              zero         <= (w_res == '0);
              eq           <= (A == B);
              carry        <= w_carry;
              negative     <= w_res[MSB];
              overflow     <= w_ovf;
              done         <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          // start is ignored here; outputs hold until the final step.
          if (w_fin) begin
            resultado    <= w_prod[WIDTH-1:0];
            resultado_hi <= w_prod[2*WIDTH-1:WIDTH];
            zero         <= (w_prod[WIDTH-1:0] == '0);
            eq           <= r_mul_eq;
            carry        <= (w_prod[2*WIDTH-1:WIDTH] != '0);
            negative     <= w_prod[MSB];
            overflow     <= 1'b0;
            done         <= 1'b1;
            busy         <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
